mips_mc_main_ctrl: RTL
======================

Name: mips_mc_main_ctrl

Overview:
- Multicycle MIPS main control FSM; the producer end of the 2-bit ALUOp interface consumed by the ALU control decoder.
- ALUOp encoding: 00 = add, 01 = sub, 10 = decode funct.
- Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode and drives every datapath enable and mux select.
- Memory accesses wait on a ready handshake.

Parameters:
ILLEGAL_TRAP, 0, 0: an illegal opcode pulses illegal_op and returns to FETCH; 1: it enters HALT until reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]; stable from the DECODE cycle onward
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  register write data: 1 = MDR, 0 = ALUOut
ir_write  output  1  instruction register load
pc_source  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
alu_op  output  2  to ALU control: 00 add, 01 sub, 10 funct
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2
reg_write  output  1  register file write
reg_dst  output  1  destination register: 1 = rd, 0 = rt
instr_done  output  1  pulse in the final cycle of each instruction
illegal_op  output  1  pulse in DECODE on an unsupported opcode
halted  output  1  high while in HALT
state  output  4  current state, for debug and coverage

Behaviour:
- Reset is synchronous, active-high: any rising edge with rst=1 loads RST, including mid-instruction. RST drives all outputs 0 and moves unconditionally to FETCH.
- Moore outputs decoded from the state register. Exception: fields noted "&mem_ready" are gated combinationally. Every signal not listed for a state is 0.
- State encoding: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=13. Codes 14-15 go to RST.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready. Holds while mem_ready=0, otherwise goes to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - any other -> illegal_op=1, then FETCH (or HALT if ILLEGAL_TRAP=1).
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; goes to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_read=1, i_or_d=1; holds until mem_ready, then MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; then FETCH.
  - MEMWR: mem_write=1, i_or_d=1, instr_done=mem_ready; holds until mem_ready, then FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1; then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1; then FETCH.
  - JUMP: pc_write=1, pc_source=10, instr_done=1; then FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
  - ADDIWB: reg_dst=0, reg_write=1, instr_done=1; then FETCH.
  - HALT: halted=1, all other outputs 0; exits only via rst.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- mem_read and mem_write are never both 1. pc_write and pc_write_cond are never both 1.
- opcode is ignored outside DECODE; changes to it in other states have no effect.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state encodings
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - PCSRC_* and SRCB_* select codes
- Optional sub-module mips_mc_ctrl_outdec: purely combinational state-to-outputs decoder, so the FSM next-state logic and output decode are verified separately.

Test Plan:
- rst=1 for 2 cycles, then 0 -> state=0 with all outputs 0 while rst high; FETCH (state=1) on the first edge after release.
- lw (opcode=100011), mem_ready=1 -> states 1,2,3,4,5,1; MEMWB has reg_write=1, mem_to_reg=1; instr_done pulses once at cycle 5.
- R-type (000000) -> EXEC has alu_op=10; ALUWB has reg_dst=1, reg_write=1; 4 cycles total. beq (000100) -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; 3 cycles.
- sw with mem_ready held 0 for 3 cycles in MEMWR -> mem_write stays 1 for 4 cycles; instr_done only in the mem_ready=1 cycle; return to FETCH.
- opcode=111111 -> illegal_op=1 for one DECODE cycle, then FETCH; with ILLEGAL_TRAP=1 -> HALT, halted=1 persists until rst.
- rst asserted in MEMRD -> next state RST with all outputs 0; no reg_write ever asserted for the aborted lw.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM
// states, ALUOp codes, datapath select codes and the control-word bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12,
        ST_HALT   = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal_op;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_outdec.sv
// Combinational state-to-control-word decoder. Outputs are Moore except the
// memory-handshake-gated fields and the DECODE-cycle illegal opcode flag.
module mips_mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output ctrl_t       ctrl
);

    // Decode the control word for the current state; unlisted fields stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_main_ctrl.sv
// Multicycle MIPS main control FSM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RST    | post-reset, all outputs low, goes to FETCH
// FETCH  | read instruction at PC, PC+4 -> PC when memory ready
// DECODE | register read, branch target precompute, dispatch on opcode
// MEMADR | lw/sw effective address A + imm
// MEMRD  | data read at ALUOut, waits for memory ready
// MEMWB  | MDR -> rt
// MEMWR  | data write at ALUOut, waits for memory ready
// EXEC   | R-type ALU operation (funct decoded)
// ALUWB  | ALUOut -> rd
// BRANCH | beq compare, conditional PC load from ALUOut
// JUMP   | PC <- jump target
// ADDIEX | A + imm
// ADDIWB | ALUOut -> rt
// HALT   | trapped on illegal opcode, leaves only via reset
module mips_mc_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       halted,
    output logic [3:0] state
);

    state_t state_q;
    logic   is_store_q;
    ctrl_t  ctrl;

    // State register and next-state sequencing; the lw/sw choice is latched
    // in DECODE so opcode is never looked at after that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RST;
            is_store_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RST:    state_q <= ST_FETCH;
                ST_FETCH:  if (mem_ready) state_q <= ST_DECODE;
                ST_DECODE: begin
                    is_store_q <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: state_q <= ST_MEMADR;
                        OP_RTYPE:     state_q <= ST_EXEC;
                        OP_BEQ:       state_q <= ST_BRANCH;
                        OP_J:         state_q <= ST_JUMP;
                        OP_ADDI:      state_q <= ST_ADDIEX;
                        default:      state_q <= ILLEGAL_TRAP ? ST_HALT : ST_FETCH;
                    endcase
                end
                ST_MEMADR: state_q <= is_store_q ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  if (mem_ready) state_q <= ST_MEMWB;
                ST_MEMWR:  if (mem_ready) state_q <= ST_FETCH;
                ST_EXEC:   state_q <= ST_ALUWB;
                ST_ADDIEX: state_q <= ST_ADDIWB;
                ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_ADDIWB:
                           state_q <= ST_FETCH;
                ST_HALT:   state_q <= ST_HALT;
                default:   state_q <= ST_RST;
            endcase
        end
    end

    mips_mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    // Fan the decoded control word out to the datapath ports.
    always_comb begin
        pc_write      = ctrl.pc_write;
        pc_write_cond = ctrl.pc_write_cond;
        i_or_d        = ctrl.i_or_d;
        mem_read      = ctrl.mem_read;
        mem_write     = ctrl.mem_write;
        mem_to_reg    = ctrl.mem_to_reg;
        ir_write      = ctrl.ir_write;
        pc_source     = ctrl.pc_source;
        alu_op        = ctrl.alu_op;
        alu_src_a     = ctrl.alu_src_a;
        alu_src_b     = ctrl.alu_src_b;
        reg_write     = ctrl.reg_write;
        reg_dst       = ctrl.reg_dst;
        instr_done    = ctrl.instr_done;
        illegal_op    = ctrl.illegal_op;
        halted        = ctrl.halted;
        state         = state_q;
    end

endmodule
